// File: rtl/sfx_pkg.sv
// Shared constants for the sound-effect sequencer: effect ids, FSM encoding and note ROM.
// Pure definitions; no latency or backpressure of its own.
package sfx_pkg;

  localparam int HALF_W  = 17;
  localparam int DUR_W   = 9;
  localparam int PRESC_W = 20;

  typedef logic [1:0] sfx_t;
  localparam sfx_t SFX_NONE  = 2'd0;
  localparam sfx_t SFX_FLAP  = 2'd1;
  localparam sfx_t SFX_SCORE = 2'd2;
  localparam sfx_t SFX_DIE   = 2'd3;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_PLAY = 2'd1;
  localparam state_t ST_GAP  = 2'd2;

  localparam logic [HALF_W-1:0] HALF_E6 = 17'd37908;
  localparam logic [HALF_W-1:0] HALF_B5 = 17'd50607;
  localparam logic [HALF_W-1:0] HALF_G5 = 17'd63776;
  localparam logic [HALF_W-1:0] HALF_E5 = 17'd75873;
  localparam logic [HALF_W-1:0] HALF_C5 = 17'd95602;

  function automatic logic [1:0] sfx_notes(input sfx_t sfx);
    case (sfx)
      SFX_FLAP:  return 2'd1;
      SFX_SCORE: return 2'd2;
      SFX_DIE:   return 2'd3;
      default:   return 2'd0;
    endcase
  endfunction

  // Unused slots return a non-zero half-period so the counter compare never underflows.
  function automatic logic [HALF_W-1:0] note_half(input sfx_t sfx, input logic [1:0] idx);
    case ({sfx, idx})
      {SFX_FLAP,  2'd0}: return HALF_E6;
      {SFX_SCORE, 2'd0}: return HALF_B5;
      {SFX_SCORE, 2'd1}: return HALF_E6;
      {SFX_DIE,   2'd0}: return HALF_G5;
      {SFX_DIE,   2'd1}: return HALF_E5;
      {SFX_DIE,   2'd2}: return HALF_C5;
      default:           return HALF_E6;
    endcase
  endfunction

  function automatic logic [DUR_W-1:0] note_dur(input sfx_t sfx, input logic [1:0] idx);
    case ({sfx, idx})
      {SFX_FLAP,  2'd0}: return 9'd40;
      {SFX_SCORE, 2'd0}: return 9'd60;
      {SFX_SCORE, 2'd1}: return 9'd120;
      {SFX_DIE,   2'd0}: return 9'd150;
      {SFX_DIE,   2'd1}: return 9'd150;
      {SFX_DIE,   2'd2}: return 9'd300;
      default:           return 9'd1;
    endcase
  endfunction

endpackage

// File: rtl/sfx_player_tone_gen.sv
// Square-wave tone generator: half-period counter plus toggle flop, sync clear and enable.
// wave_nxt is the flop's next value, so a registered consumer sees it with one-edge latency; no backpressure.
module tone_gen
  import sfx_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [HALF_W-1:0] half,
  output logic              wave_nxt
);

  logic [HALF_W-1:0] cnt;
  logic              wave;
  logic              wrap;

  assign wrap = en && (cnt == half - HALF_W'(1));

  always_comb begin
    wave_nxt = wave;
    if (clr)       wave_nxt = 1'b0;
    else if (wrap) wave_nxt = ~wave;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (en) begin
      cnt  <= wrap ? '0 : cnt + HALF_W'(1);
      wave <= wave_nxt;
    end
  end

endmodule

// File: rtl/sfx_player.sv
// Sound-effect sequencer: arbitrates game events and plays multi-note square-wave effects from a ROM.
// Event to busy/cur_sfx in one edge; no backpressure, lower-priority events are dropped.
module sfx_player
  import sfx_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 100000,
  parameter int unsigned GAP_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       evt_flap,
  input  logic       evt_score,
  input  logic       evt_die,
  input  logic       mute,
  output logic       audio,
  output logic       busy,
  output logic [1:0] cur_sfx
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0]   GAP_LAST   = (GAP_TICKS == 0) ? '0 : DUR_W'(GAP_TICKS - 1);

  state_t             state;
  logic [1:0]         note_idx;
  logic [PRESC_W-1:0] presc;
  logic [DUR_W-1:0]   tick_cnt;

  sfx_t              req;
  logic              start;
  logic              tick;
  logic              note_end;
  logic              gap_end;
  logic              last_note;
  logic              tone_clr;
  logic              wave_nxt;
  logic [HALF_W-1:0] half;
  logic [DUR_W-1:0]  dur;

  always_comb begin
    req = SFX_NONE;
    if (evt_die)        req = SFX_DIE;
    else if (evt_score) req = SFX_SCORE;
    else if (evt_flap)  req = SFX_FLAP;
  end

  // Equal priority restarts the running effect.
  assign start     = (req != SFX_NONE) && (req >= cur_sfx);
  assign half      = note_half(cur_sfx, note_idx);
  assign dur       = note_dur(cur_sfx, note_idx);
  assign tick      = (presc == PRESC_LAST);
  assign note_end  = (state == ST_PLAY) && tick && (tick_cnt == dur - DUR_W'(1));
  assign gap_end   = (state == ST_GAP) && tick && (tick_cnt == GAP_LAST);
  assign last_note = (note_idx == sfx_notes(cur_sfx) - 2'd1);
  assign tone_clr  = start || (state != ST_PLAY) || note_end;
  assign busy      = (state != ST_IDLE);

  tone_gen u_tone (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tone_clr),
    .en       (state == ST_PLAY),
    .half     (half),
    .wave_nxt (wave_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cur_sfx  <= SFX_NONE;
      note_idx <= '0;
      presc    <= '0;
      tick_cnt <= '0;
      audio    <= 1'b0;
    end else begin
      // tone_clr zeroes wave_nxt on start, note end, gap and idle, so audio drops with them.
      audio <= wave_nxt & ~mute;
      if (start) begin
        state    <= ST_PLAY;
        cur_sfx  <= req;
        note_idx <= '0;
        presc    <= '0;
        tick_cnt <= '0;
      end else begin
        case (state)
          ST_PLAY, ST_GAP: begin
            presc <= tick ? '0 : presc + PRESC_W'(1);
            if (tick) tick_cnt <= tick_cnt + DUR_W'(1);
            if (note_end) begin
              tick_cnt <= '0;
              if (last_note) begin
                state    <= ST_IDLE;
                cur_sfx  <= SFX_NONE;
                note_idx <= '0;
              end else if (GAP_TICKS == 0) begin
                note_idx <= note_idx + 2'd1;
              end else begin
                state <= ST_GAP;
              end
            end
            if (gap_end) begin
              tick_cnt <= '0;
              note_idx <= note_idx + 2'd1;
              state    <= ST_PLAY;
            end
          end
          default: begin
            state    <= ST_IDLE;
            cur_sfx  <= SFX_NONE;
            note_idx <= '0;
            presc    <= '0;
            tick_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule
